// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R/I-type ALU, beq, jal).
// Define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic             illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP) illegal <= 1'b1;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        // Speculatively computes the branch target into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms old PC + 4 for the link
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        state_d   = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic retire;
  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                  ((state_q == MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I core. It sits directly upstream of alu_control and drives the 2-bit alu_op that alu_control decodes together with funct3/funct7b5.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and raises all datapath enables and mux selects.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Stalls on a memory ready handshake and traps on illegal opcodes.

Parameters:
- CNT_W, 32, width of the performance counters. Used only when MC_PERF_CNT_EN is defined.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory has completed the current access
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register and old-PC register enable
- result_src  out  2  result mux: 00 = ALUOut, 01 = data register, 10 = ALU result
- alu_src_a  out  2  SrcA mux: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  SrcB mux: 00 = rs2, 01 = immediate, 10 = constant 4
- alu_op  out  2  to alu_control: 00 = add, 01 = subtract, 10 = decode by funct
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- reg_write  out  1  register file write enable
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset: asynchronous on rst_n low. state = FETCH (0) and illegal = 0 while reset is asserted. All outputs then take their FETCH values, except that ir_write and pc_write stay 0 unless mem_ready = 1.
- Outputs are a Moore decode of the state register, with two exceptions:
  - ir_write and pc_write in FETCH are gated by mem_ready.
  - pc_write in BEQ follows zero.
- imm_src is combinational from opcode: lw/I-type = 00, sw = 01, beq = 10, jal = 11, any other opcode = 00.
- Any output not listed for a state is 0; any select not listed is 00.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=11.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - If mem_ready = 1: ir_write=1 and pc_write=1, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch target). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 (R-type) -> EXECR
  - 0010011 (I-type) -> EXECI
  - 1100011 (beq) -> BEQ
  - 1101111 (jal) -> JAL
  - any other opcode -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: result_src=00, adr_src=1. Hold until mem_ready = 1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. mem_write stays high while stalled. Go to FETCH on mem_ready = 1.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then go to ALUWB.
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then go to ALUWB (writes the link address).
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, then go to FETCH.
- TRAP: all enables 0. illegal=1 is sticky. Only rst_n exits TRAP.
- Latency with mem_ready held at 1: beq 3 cycles; R-type, I-type, sw and jal 4 cycles; lw 5 cycles. Each stall cycle adds 1.
- Reset asserted mid-instruction: the state returns to FETCH immediately and no write enable remains asserted.
- Unused encodings 12-15: next state = FETCH, outputs are all 0.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, the block adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0]. Both reset to 0 and both wrap modulo 2^CNT_W.
- cycle_cnt increments every cycle that is out of reset and not in TRAP.
- instret_cnt increments by 1 on each retiring cycle: MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready = 1.
- When undefined, neither the ports nor the counter logic exist.

Test Plan:
- R-type add (opcode 0110011), mem_ready=1 -> states 0,1,6,7,0. alu_op=10 in EXECR; reg_write=1 only in ALUWB; 4 cycles.
- lw (0000011), mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. adr_src=1 throughout MEMREAD; reg_write with result_src=01 in MEMWB.
- beq (1100011): with zero=1, pc_write=1 and alu_op=01 in BEQ. With zero=0, pc_write=0 and the next state is FETCH.
- jal (1101111) -> states 0,1,9,7. pc_write=1 in JAL; reg_write=1 with result_src=00 in ALUWB.
- Opcode 1111111 -> TRAP, illegal=1 held for 10 cycles. Pulsing rst_n low mid-MEMWRITE gives state=0 and mem_write=0 asynchronously.
- With MC_PERF_CNT_EN, three back-to-back R-type instructions -> instret_cnt=3 and cycle_cnt=12.
